bm_cam_bank: RTL and testbench

//  Parametrised LUTRAM CAM bank: SLICES LUTRAMs, each 2^ADDR_W deep x ENTRIES wide.
//  The key is split into ADDR_W-bit slices; slice s addresses LUTRAM s; the per-entry

---
 rtl/bm_cam_pkg.sv | 26 ++
 rtl/bm_cam_prio_enc.sv | 23 ++
 rtl/lutram.sv | 24 ++
 rtl/bm_cam_bank.sv | 170 +++++++++++++++++
 tb/tb_bm_cam_bank.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bm_cam_pkg.sv
// Shared types, default sizes and the lowest-set-bit helper for the LUTRAM CAM bank.
package bm_cam_pkg;

  localparam int SLICES_DEF  = 4;
  localparam int ADDR_W_DEF  = 6;
  localparam int ENTRIES_DEF = 8;

  // Widest match vector the helper accepts; narrower vectors are zero-extended.
  localparam int LS_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } upd_state_e;

  function automatic int lowest_set(input logic [LS_MAX_W-1:0] vec);
    int r;
    r = 0;
    for (int i = LS_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/bm_cam_prio_enc.sv
// Priority encoder: hit flag and lowest set index of the CAM match vector.
// Latency: combinational, registered by the caller.
// Backpressure: none.
module bm_cam_prio_enc import bm_cam_pkg::*; #(
  parameter  int ENTRIES = ENTRIES_DEF,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] vec,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [LS_MAX_W-1:0] ext;

  always_comb begin
    ext = '0;
    ext[ENTRIES-1:0] = vec;
  end

  assign hit = |vec;
  assign idx = IDX_W'(lowest_set(ext));

endmodule

// File: rtl/lutram.sv
// LUTRAM primitive: synchronous write, asynchronous read, contents not reset.
// Latency: write visible the cycle after we; read is combinational.
// Backpressure: none, accepts a write every cycle.
module lutram #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/bm_cam_bank.sv
// LUTRAM CAM bank: one LUTRAM per key slice, entry hit = AND of slice bits and valid; BM_CAM_MASK_EN adds ternary upd_mask.
// Latency: search result 1 cycle after accept; update done 2^ADDR_W+1 cycles after accept.
// Backpressure: search_ready/upd_ready low while the update engine sweeps; search wins in IDLE.
module bm_cam_bank import bm_cam_pkg::*; #(
  parameter  int SLICES  = SLICES_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int ENTRIES = ENTRIES_DEF,
  localparam int KEY_W   = SLICES * ADDR_W,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               search_valid,
  output logic               search_ready,
  input  logic [KEY_W-1:0]   search_key,
  output logic               match_valid,
  output logic [ENTRIES-1:0] match_vec,
  output logic               match_hit,
  output logic [IDX_W-1:0]   match_idx,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic               upd_op,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [KEY_W-1:0]   upd_key,
`ifdef BM_CAM_MASK_EN
  input  logic [KEY_W-1:0]   upd_mask,
`endif
  output logic               upd_done,
  output logic               busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  upd_state_e         state;
  logic [ADDR_W-1:0]  sweep_addr;
  logic               op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   mask_q;
  logic [ENTRIES-1:0] valid_q;

  logic                            search_acc;
  logic                            upd_acc;
  logic                            idx_ok;
  logic                            upd_idx_ok;
  logic                            ram_we;
  logic [SLICES-1:0][ENTRIES-1:0]  rd_dat;
  logic [ENTRIES-1:0]              hit_vec;
  logic                            pe_hit;
  logic [IDX_W-1:0]                pe_idx;

  assign search_ready = (state == IDLE);
  assign upd_ready    = (state == IDLE) & ~search_valid;
  assign search_acc   = search_valid & search_ready;
  assign upd_acc      = upd_valid & upd_ready;
  assign upd_done     = (state == DONE);
  assign busy         = (state != IDLE);

  // Out-of-range targets still run the full sweep timing but never touch storage.
  assign idx_ok     = int'(idx_q) < ENTRIES;
  assign upd_idx_ok = int'(upd_idx) < ENTRIES;
  assign ram_we     = (state == SWEEP) & idx_ok;

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    logic [ADDR_W-1:0]  key_s;
    logic [ADDR_W-1:0]  mask_s;
    logic [ADDR_W-1:0]  ram_addr;
    logic               new_bit;
    logic [ENTRIES-1:0] wr_dat;

    assign key_s    = key_q[s*ADDR_W +: ADDR_W];
    assign mask_s   = mask_q[s*ADDR_W +: ADDR_W];
    assign new_bit  = op_q & (((sweep_addr ^ key_s) & ~mask_s) == '0);
    assign ram_addr = (state == SWEEP) ? sweep_addr : search_key[s*ADDR_W +: ADDR_W];

    // Read-modify-write: only the target entry's column changes.
    always_comb begin
      wr_dat = rd_dat[s];
      for (int e = 0; e < ENTRIES; e++) begin
        if (int'(idx_q) == e) wr_dat[e] = new_bit;
      end
    end

    lutram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRIES)
    ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (wr_dat),
      .dout (rd_dat[s])
    );
  end

  always_comb begin
    hit_vec = valid_q;
    for (int s = 0; s < SLICES; s++) begin
      hit_vec = hit_vec & rd_dat[s];
    end
  end

  bm_cam_prio_enc #(
    .ENTRIES (ENTRIES)
  ) u_prio_enc (
    .vec (hit_vec),
    .hit (pe_hit),
    .idx (pe_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sweep_addr <= '0;
      op_q       <= 1'b0;
      idx_q      <= '0;
      key_q      <= '0;
      valid_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_acc) begin
            state      <= SWEEP;
            sweep_addr <= '0;
            op_q       <= upd_op;
            idx_q      <= upd_idx;
            key_q      <= upd_key;
            if (!upd_op && upd_idx_ok) valid_q[upd_idx] <= 1'b0;
          end
        end
        SWEEP: begin
          if (sweep_addr == LAST_ADDR) state <= DONE;
          else                         sweep_addr <= sweep_addr + 1'b1;
        end
        DONE: begin
          if (idx_ok) valid_q[idx_q] <= op_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BM_CAM_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask_q <= '0;
    else if (upd_acc) mask_q <= upd_mask;
  end
`else
  assign mask_q = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_valid <= 1'b0;
      match_vec   <= '0;
      match_hit   <= 1'b0;
      match_idx   <= '0;
    end else begin
      match_valid <= search_acc;
      if (search_acc) begin
        match_vec <= hit_vec;
        match_hit <= pe_hit;
        match_idx <= pe_idx;
      end
    end
  end

endmodule

// File: tb/tb_bm_cam_bank.sv
// Self-checking bench for bm_cam_bank: directed scenarios plus randomized traffic
// compared every cycle against an entry-table model of the CAM.
`timescale 1ns/1ps
module tb_bm_cam_bank;

  localparam int SLICES    = 4;
  localparam int ADDR_W    = 6;
  localparam int ENTRIES   = 8;
  localparam int KEY_W     = SLICES * ADDR_W;
  localparam int IDX_W     = $clog2(ENTRIES);
  localparam int SWEEP_CYC = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               search_valid = 1'b0;
  logic [KEY_W-1:0]   search_key = '0;
  logic               upd_valid = 1'b0;
  logic               upd_op = 1'b0;
  logic [IDX_W-1:0]   upd_idx = '0;
  logic [KEY_W-1:0]   upd_key = '0;
`ifdef BM_CAM_MASK_EN
  logic [KEY_W-1:0]   upd_mask = '0;
`endif
  logic               search_ready;
  logic               match_valid;
  logic [ENTRIES-1:0] match_vec;
  logic               match_hit;
  logic [IDX_W-1:0]   match_idx;
  logic               upd_ready;
  logic               upd_done;
  logic               busy;

  always #5 clk = ~clk;

  bm_cam_bank #(
    .SLICES  (SLICES),
    .ADDR_W  (ADDR_W),
    .ENTRIES (ENTRIES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .search_valid (search_valid),
    .search_ready (search_ready),
    .search_key   (search_key),
    .match_valid  (match_valid),
    .match_vec    (match_vec),
    .match_hit    (match_hit),
    .match_idx    (match_idx),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_op       (upd_op),
    .upd_idx      (upd_idx),
    .upd_key      (upd_key),
`ifdef BM_CAM_MASK_EN
    .upd_mask     (upd_mask),
`endif
    .upd_done     (upd_done),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a table of (valid, key, mask) per entry plus a countdown of busy cycles.
  logic             m_valid [ENTRIES];
  logic [KEY_W-1:0] m_key   [ENTRIES];
  logic [KEY_W-1:0] m_mask  [ENTRIES];
  int               m_rem = 0;
  logic             p_op = 1'b0;
  int               p_idx = 0;
  logic [KEY_W-1:0] p_key = '0;
  logic [KEY_W-1:0] p_mask = '0;
  logic               e_mv  = 1'b0;
  logic [ENTRIES-1:0] e_vec = '0;

  function automatic logic [ENTRIES-1:0] model_lookup(input logic [KEY_W-1:0] k);
    logic [ENTRIES-1:0] r;
    for (int e = 0; e < ENTRIES; e++)
      r[e] = m_valid[e] && (((k ^ m_key[e]) & ~m_mask[e]) == '0);
    return r;
  endfunction

  function automatic int lowest(input logic [ENTRIES-1:0] v);
    int r = 0;
    for (int i = ENTRIES - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    bit acc_s, acc_u;
    for (int e = 0; e < ENTRIES; e++) begin
      m_valid[e] = 1'b0; m_key[e] = '0; m_mask[e] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
        m_rem = 0; e_mv = 1'b0; e_vec = '0;
      end else begin
        acc_s = search_valid && (m_rem == 0);
        acc_u = upd_valid && (m_rem == 0) && !search_valid;
        if (m_rem == 1 && p_idx < ENTRIES) begin
          m_valid[p_idx] = p_op;
          if (p_op) begin
            m_key[p_idx]  = p_key;
            m_mask[p_idx] = p_mask;
          end
        end
        if (m_rem > 0) m_rem--;
        e_mv = acc_s;
        if (acc_s) e_vec = model_lookup(search_key);
        if (acc_u) begin
          m_rem = SWEEP_CYC + 1;
          p_op  = upd_op;
          p_idx = int'(upd_idx);
          p_key = upd_key;
`ifdef BM_CAM_MASK_EN
          p_mask = upd_mask;
`else
          p_mask = '0;
`endif
          if (!upd_op && p_idx < ENTRIES) m_valid[p_idx] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("busy",         busy,         m_rem != 0);
        chk("upd_done",     upd_done,     m_rem == 1);
        chk("search_ready", search_ready, m_rem == 0);
        chk("upd_ready",    upd_ready,    (m_rem == 0) && !search_valid);
        chk("match_valid",  match_valid,  e_mv);
        chk("match_vec",    match_vec,    e_vec);
        chk("match_hit",    match_hit,    |e_vec);
        chk("match_idx",    match_idx,    lowest(e_vec));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_search(input logic [KEY_W-1:0] k);
    @(posedge clk); #1;
    search_valid = 1'b1;
    search_key   = k;
    @(posedge clk); #1;
    search_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_update(input logic op, input int idx, input logic [KEY_W-1:0] k,
                              input logic [KEY_W-1:0] m);
    @(posedge clk); #1;
    upd_valid = 1'b1;
    upd_op    = op;
    upd_idx   = IDX_W'(idx);
    upd_key   = k;
`ifdef BM_CAM_MASK_EN
    upd_mask  = m;
`else
    if (m != '0) $display("note: mask ignored in this build");
`endif
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!upd_done && lat < 200);
  endtask

  initial begin
    int lat;
    int ready_cnt;
    int done_cnt;
    logic [KEY_W-1:0] pool [6];

    // 1: reset state, then an empty-table search
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_match_valid", match_valid, 0);
    chk("rst_match_vec",   match_vec,   0);
    chk("rst_upd_done",    upd_done,    0);
    chk("rst_busy",        busy,        0);
    #2 rst = 1'b0;
    cmp_on = 1'b1;
    do_search(24'h000000);
    chk("t1_match_valid", match_valid, 1);
    chk("t1_match_vec",   match_vec,   8'h00);
    chk("t1_match_hit",   match_hit,   0);

    // 2: install idx3, latency and exact-match behaviour
    start_update(1'b1, 3, 24'hABCDEF, '0);
    wait_done(lat);
    chk("t2_upd_latency", lat, 65);
    do_search(24'hABCDEF);
    chk("t2_hit_vec", match_vec, 8'h08);
    chk("t2_hit_idx", match_idx, 3);
    do_search(24'hABCDEE);
    chk("t2_miss_vec", match_vec, 8'h00);

    // 3: duplicate key in two entries, then delete the lower one
    start_update(1'b1, 5, 24'h123456, '0);
    wait_done(lat);
    start_update(1'b1, 1, 24'h123456, '0);
    wait_done(lat);
    do_search(24'h123456);
    chk("t3_dup_vec", match_vec, 8'h22);
    chk("t3_dup_idx", match_idx, 1);
    start_update(1'b0, 1, '0, '0);
    wait_done(lat);
    chk("t3_del_latency", lat, 65);
    do_search(24'h123456);
    chk("t3_del_vec", match_vec, 8'h20);
    chk("t3_del_idx", match_idx, 5);

    // 4: simultaneous search and update requests
    @(posedge clk); #1;
    search_valid = 1'b1; search_key = 24'hABCDEF;
    upd_valid = 1'b1; upd_op = 1'b1; upd_idx = 3'd6; upd_key = 24'h777777;
`ifdef BM_CAM_MASK_EN
    upd_mask = '0;
`endif
    #1;
    chk("t4_upd_ready_blocked", upd_ready, 0);
    chk("t4_search_ready",      search_ready, 1);
    @(posedge clk); #1;
    search_valid = 1'b0;
    @(negedge clk);
    chk("t4_search_served", match_vec, 8'h08);
    chk("t4_upd_ready_next", upd_ready, 1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    ready_cnt = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (search_ready) ready_cnt++;
    end while (!upd_done && lat < 200);
    chk("t4_search_ready_during_sweep", ready_cnt, 0);
    chk("t4_upd_latency", lat, 65);

    // 5: reset in the middle of a sweep
    start_update(1'b1, 2, 24'h2468AC, '0);
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_done_after_rst", upd_done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    done_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (upd_done) done_cnt++;
    end
    chk("t5_no_upd_done", done_cnt, 0);
    do_search(24'h2468AC);
    chk("t5_aborted_vec", match_vec, 8'h00);
    do_search(24'hABCDEF);
    chk("t5_cleared_vec", match_vec, 8'h00);

`ifdef BM_CAM_MASK_EN
    // 6: ternary entry with the low slice fully don't-care
    start_update(1'b1, 0, 24'h00003F, 24'h00003F);
    wait_done(lat);
    do_search(24'h000000);
    chk("t6_zero_vec", match_vec, 8'h01);
    chk("t6_zero_idx", match_idx, 0);
    do_search(24'h000015);
    chk("t6_mid_vec", match_vec, 8'h01);
    do_search(24'h000040);
    chk("t6_miss_vec", match_vec, 8'h00);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 6; i++) pool[i] = KEY_W'($urandom);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      search_valid = ($urandom_range(0, 2) == 0);
      search_key   = ($urandom_range(0, 2) != 0) ? pool[$urandom_range(0, 5)] : KEY_W'($urandom);
      upd_valid    = ($urandom_range(0, 7) == 0);
      upd_op       = ($urandom_range(0, 3) != 0);
      upd_idx      = IDX_W'($urandom_range(0, ENTRIES - 1));
      upd_key      = pool[$urandom_range(0, 5)];
`ifdef BM_CAM_MASK_EN
      upd_mask     = ($urandom_range(0, 1) == 0) ? '0 : (KEY_W'($urandom) & KEY_W'($urandom));
`endif
    end
    @(posedge clk); #1;
    search_valid = 1'b0;
    upd_valid    = 1'b0;
    repeat (SWEEP_CYC + 4) @(negedge clk);
    cmp_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
